// File: rtl/noc_config_pkg.sv
// -----------------------------------------------------------------------------
// noc_config_pkg
// Shared NoC definitions used by the network-interface blocks.
//   flit_type_e : flit kind carried in the flit_type bit (header / payload).
//   noc_hdr_t   : header flit layout at the default mesh widths, LSB first:
//                 dest_x, dest_y, src_x, src_y, length. Blocks built with
//                 non-default widths declare the same layout from their own
//                 parameters.
// -----------------------------------------------------------------------------
package noc_config_pkg;

    typedef enum logic {
        FLIT_HEADER  = 1'b0,
        FLIT_PAYLOAD = 1'b1
    } flit_type_e;

    localparam int NOC_X_WIDTH    = 3;
    localparam int NOC_Y_WIDTH    = 3;
    localparam int NOC_MAX_LENGTH = 16;
    localparam int NOC_LEN_WIDTH  = $clog2(NOC_MAX_LENGTH + 1);

    // Declared MSB first, so dest_x lands in the least significant bits.
    typedef struct packed {
        logic [NOC_LEN_WIDTH-1:0] length;
        logic [NOC_Y_WIDTH-1:0]   src_y;
        logic [NOC_X_WIDTH-1:0]   src_x;
        logic [NOC_Y_WIDTH-1:0]   dest_y;
        logic [NOC_X_WIDTH-1:0]   dest_x;
    } noc_hdr_t;

endpackage

// File: rtl/noc_local_packetizer_if.sv
// -----------------------------------------------------------------------------
// noc_local_packetizer_if
// Bundles the three handshake channels of the local packetizer:
//   cmd  : cmd_valid/cmd_ready, cmd_dest_x, cmd_dest_y, cmd_length
//   data : data_valid/data_ready, data
//   flit : flit_valid/flit_ready, flit_type, flit_tail, flit_data
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid and ready are both 1. A producer holding valid=1 keeps its
// payload stable until that transfer; ready may depend on state but never
// on the valid of the same channel.
// Modports: master = command/data source and flit sink (router side),
//           slave  = the packetizer.
// -----------------------------------------------------------------------------
interface noc_local_packetizer_if #(
    parameter int X_WIDTH    = 3,
    parameter int Y_WIDTH    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [X_WIDTH-1:0]    cmd_dest_x;
    logic [Y_WIDTH-1:0]    cmd_dest_y;
    logic [LEN_WIDTH-1:0]  cmd_length;

    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data;

    logic                  flit_valid;
    logic                  flit_ready;
    logic                  flit_type;
    logic                  flit_tail;
    logic [DATA_WIDTH-1:0] flit_data;

    modport master (
        output cmd_valid, cmd_dest_x, cmd_dest_y, cmd_length,
        output data_valid, data,
        output flit_ready,
        input  cmd_ready, data_ready,
        input  flit_valid, flit_type, flit_tail, flit_data
    );

    modport slave (
        input  cmd_valid, cmd_dest_x, cmd_dest_y, cmd_length,
        input  data_valid, data,
        input  flit_ready,
        output cmd_ready, data_ready,
        output flit_valid, flit_type, flit_tail, flit_data
    );
endinterface

// File: rtl/noc_flit_out_slot.sv
// -----------------------------------------------------------------------------
// noc_flit_out_slot
// Single-entry registered valid/ready output stage.
//   clk, rst : clock, synchronous active-high reset (empties the slot)
//   load_i   : write data_i into the slot; honoured only when free_o=1
//   data_i   : entry to load
//   ready_i  : downstream accepts the current entry
//   valid_o  : slot holds an entry
//   data_o   : registered entry, stable while valid_o && !ready_i
//   free_o   : slot can take a new entry this cycle (empty or draining)
// -----------------------------------------------------------------------------
module noc_flit_out_slot #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A draining entry frees the slot in the same cycle, so a new entry can
    // follow it with no bubble.
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i && free_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/noc_local_packetizer.sv
// -----------------------------------------------------------------------------
// noc_local_packetizer
// Turns a packet command plus a payload beat stream into the flit stream of
// the router's local input port: one header flit, then the payload flits,
// tail marked on the last flit. Output is registered, 1 flit/cycle.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : cmd / data / flit channels (slave modport)
//   pkt_count    : number of tail flits delivered, wraps at 16 bits
//   length_error : sticky, a command asked for more than MAX_LENGTH flits
//   dbg_state_o  : FSM state (0 = IDLE, 1 = PAYLOAD)
// -----------------------------------------------------------------------------
module noc_local_packetizer
    import noc_config_pkg::*;
#(
    parameter int X          = 0,
    parameter int Y          = 0,
    parameter int X_WIDTH    = 3,
    parameter int Y_WIDTH    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LENGTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_local_packetizer_if.slave bus,
    output logic [15:0]          pkt_count,
    output logic                 length_error,
    output logic [0:0]           dbg_state_o
);
    localparam int LEN_WIDTH = $clog2(MAX_LENGTH + 1);
    localparam int HDR_WIDTH = 2 * X_WIDTH + 2 * Y_WIDTH + LEN_WIDTH;
    localparam int SLOT_W    = DATA_WIDTH + 2;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    if (DATA_WIDTH < HDR_WIDTH) begin : g_width_check
        $error("noc_local_packetizer: DATA_WIDTH too small for header fields");
    end

    typedef struct packed {
        logic [LEN_WIDTH-1:0] length;
        logic [Y_WIDTH-1:0]   src_y;
        logic [X_WIDTH-1:0]   src_x;
        logic [Y_WIDTH-1:0]   dest_y;
        logic [X_WIDTH-1:0]   dest_x;
    } hdr_t;

    typedef struct packed {
        flit_type_e            ftype;
        logic                  tail;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    logic [0:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 len_err_q, len_err_d;
    logic [15:0]          pkt_count_q;

    logic                 slot_free;
    logic                 slot_valid;
    logic [SLOT_W-1:0]    slot_data;
    slot_t                slot_out;
    slot_t                slot_in;
    logic                 load;

    logic                 cmd_fire;
    logic                 data_fire;
    logic                 over_len;
    logic [LEN_WIDTH-1:0] eff_len;
    hdr_t                 hdr;

    // Ready outputs are gated by rst so nothing is consumed while in reset.
    assign bus.cmd_ready  = !rst && (state_q == ST_IDLE) && slot_free;
    assign bus.data_ready = !rst && (state_q == ST_PAYLOAD) && slot_free;
    assign cmd_fire       = bus.cmd_valid && bus.cmd_ready;
    assign data_fire      = bus.data_valid && bus.data_ready;

    assign over_len = bus.cmd_length > LEN_WIDTH'(MAX_LENGTH);
    assign eff_len  = over_len ? LEN_WIDTH'(MAX_LENGTH) : bus.cmd_length;

    always_comb begin
        hdr        = '0;
        hdr.dest_x = bus.cmd_dest_x;
        hdr.dest_y = bus.cmd_dest_y;
        hdr.src_x  = X_WIDTH'(X);
        hdr.src_y  = Y_WIDTH'(Y);
        hdr.length = eff_len;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        len_err_d   = len_err_q;
        load        = 1'b0;
        slot_in     = '0;
        if (cmd_fire) begin
            load          = 1'b1;
            slot_in.ftype = FLIT_HEADER;
            slot_in.tail  = (eff_len == '0);
            slot_in.data  = DATA_WIDTH'(hdr);
            if (over_len) begin
                len_err_d = 1'b1;
            end
            // A zero-length packet is complete with its header.
            if (eff_len != '0) begin
                remaining_d = eff_len;
                state_d     = ST_PAYLOAD;
            end
        end else if (data_fire) begin
            load          = 1'b1;
            slot_in.ftype = FLIT_PAYLOAD;
            slot_in.tail  = (remaining_q == LEN_WIDTH'(1));
            slot_in.data  = bus.data;
            remaining_d   = remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            len_err_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            len_err_q   <= len_err_d;
            if (slot_valid && bus.flit_ready && slot_out.tail) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
        end
    end

    noc_flit_out_slot #(
        .WIDTH (SLOT_W)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (slot_in),
        .ready_i (bus.flit_ready),
        .valid_o (slot_valid),
        .data_o  (slot_data),
        .free_o  (slot_free)
    );

    assign slot_out       = slot_t'(slot_data);
    assign bus.flit_valid = slot_valid;
    assign bus.flit_type  = slot_out.ftype;
    assign bus.flit_tail  = slot_out.tail;
    assign bus.flit_data  = slot_out.data;

    assign pkt_count    = pkt_count_q;
    assign length_error = len_err_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_noc_local_packetizer.sv
// -----------------------------------------------------------------------------
// tb_noc_local_packetizer
// Directed steps followed by randomized packets for noc_local_packetizer.
// Expected flits come from a packet-level model: each command expands into
// its header word (fields placed by arithmetic) and its payload beats.
// -----------------------------------------------------------------------------
module tb_noc_local_packetizer;
    import noc_config_pkg::*;

    localparam int X    = 1;
    localparam int Y    = 0;
    localparam int XW   = 3;
    localparam int YW   = 3;
    localparam int DW   = 32;
    localparam int MAXL = 16;
    localparam int LW   = $clog2(MAXL + 1);
    localparam int FW   = DW + 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_count;
    logic        length_error;
    logic [0:0]  dbg_state;

    always #5 clk = ~clk;

    noc_local_packetizer_if #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) bus ();

    noc_local_packetizer #(
        .X(X), .Y(Y), .X_WIDTH(XW), .Y_WIDTH(YW),
        .DATA_WIDTH(DW), .MAX_LENGTH(MAXL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .pkt_count    (pkt_count),
        .length_error (length_error),
        .dbg_state_o  (dbg_state)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [FW-1:0] exp_q[$];
    int            xfer_cyc_q[$];
    int            exp_pkt     = 0;
    bit            exp_len_err = 1'b0;

    function automatic int eff_len(input int len);
        return (len > MAXL) ? MAXL : len;
    endfunction

    function automatic logic [DW-1:0] hdr_word(input int dx, input int dy, input int len);
        longint w;
        w = longint'(dx)
          + longint'(dy)          * (2 ** XW)
          + longint'(X)           * (2 ** (XW + YW))
          + longint'(Y)           * (2 ** (2 * XW + YW))
          + longint'(eff_len(len)) * (2 ** (2 * XW + 2 * YW));
        return DW'(w);
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [FW-1:0] held_flit;
    bit            held = 1'b0;

    always @(negedge clk) begin
        logic [FW-1:0] cur;
        logic [FW-1:0] e;
        cur = {bus.flit_type, bus.flit_tail, bus.flit_data};
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) check("hold_stable", {1'b1, cur}, {1'b1, held_flit} & {bus.flit_valid, {FW{1'b1}}});
            held      = bus.flit_valid && !bus.flit_ready;
            held_flit = cur;
            if (bus.flit_valid && bus.flit_ready) begin
                if (exp_q.size() == 0) begin
                    check("flit_expected", 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("flit", cur, e);
                    if (e[FW-2]) exp_pkt++;
                end
                xfer_cyc_q.push_back(cycle);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_fire(input bit is_cmd);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (is_cmd ? bus.cmd_ready : bus.data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(is_cmd ? "cmd_timeout" : "data_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Sends a command and up to beat_limit of its payload beats.
    task automatic send_pkt(input int dx, input int dy, input int len,
                            input logic [DW-1:0] base, input int max_gap,
                            input int beat_limit);
        int e;
        int n;
        e = eff_len(len);
        n = (beat_limit < e) ? beat_limit : e;
        exp_q.push_back({1'b0, (e == 0), hdr_word(dx, dy, len)});
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b1, (i == e - 1), base + DW'(i)});
        bus.cmd_valid  = 1'b1;
        bus.cmd_dest_x = XW'(dx);
        bus.cmd_dest_y = YW'(dy);
        bus.cmd_length = LW'(len);
        wait_fire(1'b1);
        bus.cmd_valid = 1'b0;
        if (len > MAXL) exp_len_err = 1'b1;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            bus.data_valid = 1'b1;
            bus.data       = base + DW'(i);
            wait_fire(1'b0);
            bus.data_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        bus.flit_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.flit_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_drained"}, {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hdr_word_t_check : begin end
        bus.cmd_valid  = 1'b0;
        bus.cmd_dest_x = '0;
        bus.cmd_dest_y = '0;
        bus.cmd_length = '0;
        bus.data_valid = 1'b0;
        bus.data       = '0;
        bus.flit_ready = 1'b1;

        // Reset: readies held low even with valids asserted.
        rst = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.data_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        check("rst_data_ready", {63'd0, bus.data_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.data_valid = 1'b0;
        @(negedge clk);
        check("rst_outputs", {bus.flit_valid, bus.flit_type, bus.flit_tail, bus.flit_data},
              {3'b000, DW'(0)});
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_length_error", {63'd0, length_error}, 64'd0);
        @(posedge clk);
        #1;

        // 1: zero-length packet, header visible the cycle after the handshake.
        begin
            noc_hdr_t h;
            send_pkt(2, 1, 0, '0, 0, 0);
            @(negedge clk);
            check("t1_valid_type_tail", {bus.flit_valid, bus.flit_type, bus.flit_tail}, 3'b101);
            h = noc_hdr_t'(bus.flit_data[$bits(noc_hdr_t)-1:0]);
            check("t1_fields", {h.dest_x, h.dest_y, h.src_x, h.src_y, h.length},
                  {3'd2, 3'd1, 3'd1, 3'd0, 5'd0});
            check("t1_upper_zero", 64'(bus.flit_data >> $bits(noc_hdr_t)), 64'd0);
            @(posedge clk);
            #1;
            drain("t1");
            check("t1_pkt_count", 64'(pkt_count), 64'd1);
        end

        // 2: len 4 streamed, 5 flits on consecutive cycles, cmd_ready low in PAYLOAD.
        xfer_cyc_q.delete();
        fork
            send_pkt(3, 2, 4, 32'hA0, 0, 99);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.cmd_ready) break;
                end
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("t2_cmd_ready_payload", {63'd0, bus.cmd_ready}, 64'd0);
                end
                @(negedge clk);
                check("t2_cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);
            end
        join
        drain("t2");
        check("t2_flit_count", 64'(xfer_cyc_q.size()), 64'd5);
        if (xfer_cyc_q.size() == 5)
            check("t2_consecutive", 64'(xfer_cyc_q[4] - xfer_cyc_q[0]), 64'd4);
        check("t2_pkt_count", 64'(pkt_count), 64'(exp_pkt));

        // 3: backpressure while 0xA1 sits in the output register.
        fork
            send_pkt(1, 1, 4, 32'hA0, 0, 99);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (bus.flit_valid && bus.flit_type && bus.flit_data == 32'hA0) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("t3_saw_a0", {63'd0, seen}, 64'd1);
                @(posedge clk);
                #1;
                bus.flit_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t3_hold", {bus.flit_valid, bus.data_ready, bus.flit_data},
                          {2'b10, 32'hA1});
                end
                @(posedge clk);
                #1;
                bus.flit_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("t3_resume", {bus.flit_valid, bus.flit_data}, {1'b1, 32'hA2});
            end
        join
        drain("t3");

        // 4: two len-1 packets back to back.
        xfer_cyc_q.delete();
        send_pkt(4, 3, 1, 32'h11, 0, 99);
        send_pkt(5, 4, 1, 32'h22, 0, 99);
        drain("t4");
        check("t4_flit_count", 64'(xfer_cyc_q.size()), 64'd4);
        if (xfer_cyc_q.size() == 4)
            check("t4_consecutive", 64'(xfer_cyc_q[3] - xfer_cyc_q[0]), 64'd3);
        check("t4_pkt_count", 64'(pkt_count), 64'd5);

        // 5: oversize command clamps to MAX_LENGTH and sets the sticky error.
        send_pkt(7, 7, 20, 32'h100, 0, 99);
        drain("t5a");
        check("t5_len_err", {63'd0, length_error}, 64'd1);
        send_pkt(0, 5, 2, 32'h200, 0, 99);
        drain("t5b");
        check("t5_len_err_sticky", {63'd0, length_error}, {63'd0, exp_len_err});
        check("t5_pkt_count", 64'(pkt_count), 64'(exp_pkt));

        // 6: reset after two payload flits of a len-4 packet.
        send_pkt(6, 2, 4, 32'h300, 0, 2);
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_q.delete();
        exp_pkt     = 0;
        exp_len_err = 1'b0;
        @(negedge clk);
        check("t6_flit_valid", {63'd0, bus.flit_valid}, 64'd0);
        check("t6_pkt_count", 64'(pkt_count), 64'd0);
        check("t6_len_err", {63'd0, length_error}, 64'd0);
        // Payload beats offered while idle must not be consumed.
        bus.data_valid = 1'b1;
        bus.data       = 32'hDEAD;
        repeat (3) begin
            @(negedge clk);
            check("t6_idle_data", {bus.data_ready, bus.flit_valid}, 2'b00);
        end
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        send_pkt(3, 6, 0, '0, 0, 0);
        drain("t6");
        check("t6_pkt_after", 64'(pkt_count), 64'd1);

        // Randomized packets with random gaps and random flit_ready.
        begin
            bit done;
            done = 1'b0;
            fork
                begin
                    for (int p = 0; p < 25; p++)
                        send_pkt($urandom_range(0, 7), $urandom_range(0, 7),
                                 $urandom_range(0, MAXL + 3), DW'($urandom), 2, 99);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        bus.flit_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
        end
        drain("rand");
        check("rand_pkt_count", 64'(pkt_count), 64'(exp_pkt));
        check("rand_len_err", {63'd0, length_error}, {63'd0, exp_len_err});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
